// File: rtl/vga_pattern_gen_if.sv
// Video output bundle of the pattern generator: pattern select in, colour and sync out.
interface vga_pattern_gen_if #(
  parameter int unsigned COLOR_W = 4
);
  logic [1:0]         mode;
  logic [COLOR_W-1:0] redOut;
  logic [COLOR_W-1:0] greenOut;
  logic [COLOR_W-1:0] blueOut;
  logic               hSync;
  logic               vSync;
  logic               videoOn;
  logic               frameStart;

  modport master (
    input  mode,
    output redOut, greenOut, blueOut, hSync, vSync, videoOn, frameStart
  );

  modport slave (
    output mode,
    input  redOut, greenOut, blueOut, hSync, vSync, videoOn, frameStart
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: solid, colour bars, checkerboard and a
// bouncing block, with colour and sync leaving through a single register stage.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned COLOR_W    = 4,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned BLOCK_SIZE = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  vga_pattern_gen_if.master vga
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW           = $clog2(H_TOTAL);
  localparam int unsigned VW           = $clog2(V_TOTAL);
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned BAR_W        = H_ACTIVE / 8;
  localparam int unsigned BPW          = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned BS_LOG       = $clog2(BLOCK_SIZE);
  localparam int unsigned X_MAX        = H_ACTIVE - BLOCK_SIZE;
  localparam int unsigned Y_MAX        = V_ACTIVE - BLOCK_SIZE;

  logic [HW-1:0]  h_count;
  logic [VW-1:0]  v_count;
  logic [1:0]     mode_reg;
  logic [BPW-1:0] bar_pos;
  logic [2:0]     bar_idx;
  logic [HW-1:0]  bx;
  logic [VW-1:0]  by;
  logic           dx_pos;
  logic           dy_pos;

  logic           line_end_c;
  logic           frame_end_c;
  logic           block_tick_c;
  logic           active_c;
  logic           in_block_c;
  logic           hsync_act_c;
  logic           vsync_act_c;
  logic           frame_start_c;
  logic [2:0]     pat_rgb_c;

  assign line_end_c   = (h_count == HW'(H_TOTAL - 1));
  assign frame_end_c  = line_end_c && (v_count == VW'(V_TOTAL - 1));
  assign block_tick_c = (h_count == '0) && (v_count == VW'(V_ACTIVE));

  // Pixel/line counters
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (line_end_c) begin
      h_count <= '0;
      v_count <= (v_count == VW'(V_TOTAL - 1)) ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Pattern select only changes across the frame boundary
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mode_reg <= 2'd0;
    end else if (frame_end_c) begin
      mode_reg <= vga.mode;
    end
  end

  // Bar index tracks h_count incrementally so no divider is needed
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      bar_pos <= '0;
      bar_idx <= 3'd0;
    end else if (line_end_c) begin
      bar_pos <= '0;
      bar_idx <= 3'd0;
    end else if (bar_pos == BPW'(BAR_W - 1)) begin
      bar_pos <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + BPW'(1);
    end
  end

  // Block position: one step per frame, reflecting off the edges in the same step
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      bx     <= '0;
      by     <= '0;
      dx_pos <= 1'b1;
      dy_pos <= 1'b1;
    end else if (block_tick_c) begin
      if (dx_pos) begin
        if (bx == HW'(X_MAX)) begin
          dx_pos <= 1'b0;
          bx     <= bx - HW'(1);
        end else begin
          bx <= bx + HW'(1);
        end
      end else if (bx == '0) begin
        dx_pos <= 1'b1;
        bx     <= HW'(1);
      end else begin
        bx <= bx - HW'(1);
      end

      if (dy_pos) begin
        if (by == VW'(Y_MAX)) begin
          dy_pos <= 1'b0;
          by     <= by - VW'(1);
        end else begin
          by <= by + VW'(1);
        end
      end else if (by == '0) begin
        dy_pos <= 1'b1;
        by     <= VW'(1);
      end else begin
        by <= by - VW'(1);
      end
    end
  end

  // Pixel decode of the current counter values; rgb bits are (r,g,b) all-ones flags
  always_comb begin
    active_c      = (32'(h_count) < H_ACTIVE) && (32'(v_count) < V_ACTIVE);
    in_block_c    = (32'(h_count) >= 32'(bx)) && (32'(h_count) < 32'(bx) + BLOCK_SIZE) &&
                    (32'(v_count) >= 32'(by)) && (32'(v_count) < 32'(by) + BLOCK_SIZE);
    hsync_act_c   = (32'(h_count) >= H_SYNC_START) && (32'(h_count) < H_SYNC_END);
    vsync_act_c   = (32'(v_count) >= V_SYNC_START) && (32'(v_count) < V_SYNC_END);
    frame_start_c = (h_count == '0) && (v_count == '0);
    pat_rgb_c     = 3'b000;
    case (mode_reg)
      2'd0: pat_rgb_c = 3'b111;
      2'd1: begin
        case (bar_idx)
          3'd0:    pat_rgb_c = 3'b111;
          3'd1:    pat_rgb_c = 3'b110;
          3'd2:    pat_rgb_c = 3'b011;
          3'd3:    pat_rgb_c = 3'b010;
          3'd4:    pat_rgb_c = 3'b101;
          3'd5:    pat_rgb_c = 3'b100;
          3'd6:    pat_rgb_c = 3'b001;
          default: pat_rgb_c = 3'b000;
        endcase
      end
      2'd2:    pat_rgb_c = (h_count[BS_LOG] ^ v_count[BS_LOG]) ? 3'b000 : 3'b111;
      default: pat_rgb_c = in_block_c ? 3'b010 : 3'b001;
    endcase
    if (!active_c) begin
      pat_rgb_c = 3'b000;
    end
  end

  // Single output stage keeps colour and sync aligned
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      vga.redOut     <= '0;
      vga.greenOut   <= '0;
      vga.blueOut    <= '0;
      vga.hSync      <= ~SYNC_POL;
      vga.vSync      <= ~SYNC_POL;
      vga.videoOn    <= 1'b0;
      vga.frameStart <= 1'b0;
    end else begin
      vga.redOut     <= {COLOR_W{pat_rgb_c[2]}};
      vga.greenOut   <= {COLOR_W{pat_rgb_c[1]}};
      vga.blueOut    <= {COLOR_W{pat_rgb_c[0]}};
      vga.hSync      <= hsync_act_c ? SYNC_POL : ~SYNC_POL;
      vga.vSync      <= vsync_act_c ? SYNC_POL : ~SYNC_POL;
      vga.videoOn    <= active_c;
      vga.frameStart <= frame_start_c;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken mode so many frames fit in a short run.
module tb_vga_pattern_gen;

  localparam int unsigned HA = 32, HFP = 2, HS = 4, HB = 2;
  localparam int unsigned VA = 24, VFP = 1, VS = 2, VB = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned BS = 4;
  localparam bit          SP = 1'b0;
  localparam int unsigned HT = HA + HFP + HS + HB;
  localparam int unsigned VT = VA + VFP + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          hs;
    logic          vs;
    logic          von;
    logic          fs;
  } px_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  vga_pattern_gen_if #(.COLOR_W(CW)) vif ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(CW), .SYNC_POL(SP), .BLOCK_SIZE(BS)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .vga    (vif)
  );

  initial forever #5 clk_in = ~clk_in;

  px_t         exp_q[$];
  int          tag_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          started = 1'b0;
  int unsigned n = 0;
  logic [1:0]  cur_mode = 2'd0;

  function automatic px_t rst_px();
    px_t p;
    p     = '0;
    p.hs  = ~SP;
    p.vs  = ~SP;
    return p;
  endfunction

  // Triangle wave: position after k one-pixel steps bouncing between 0 and lim
  function automatic int unsigned tri_pos(int unsigned k, int unsigned lim);
    int unsigned r;
    r = k % (2 * lim);
    return (r <= lim) ? r : 2 * lim - r;
  endfunction

  // Expected output for the idx-th pixel emitted since reset, shown in pattern m
  function automatic px_t model_px(int unsigned idx, logic [1:0] m);
    int unsigned pos, k, h, v, bx, by;
    logic [2:0]  rgb;
    px_t         p;
    pos = idx % FRAME;
    k   = idx / FRAME;
    h   = pos % HT;
    v   = pos / HT;
    bx  = tri_pos(k, HA - BS);
    by  = tri_pos(k, VA - BS);
    case (m)
      2'd0: rgb = 3'b111;
      2'd1: begin
        case (h / (HA / 8))
          0:       rgb = 3'b111;
          1:       rgb = 3'b110;
          2:       rgb = 3'b011;
          3:       rgb = 3'b010;
          4:       rgb = 3'b101;
          5:       rgb = 3'b100;
          6:       rgb = 3'b001;
          default: rgb = 3'b000;
        endcase
      end
      2'd2:    rgb = (((h / BS) + (v / BS)) % 2 == 0) ? 3'b111 : 3'b000;
      default: rgb = (h >= bx && h < bx + BS && v >= by && v < by + BS) ? 3'b010 : 3'b001;
    endcase
    p.von = (h < HA) && (v < VA);
    if (!p.von) rgb = 3'b000;
    p.r  = {CW{rgb[2]}};
    p.g  = {CW{rgb[1]}};
    p.b  = {CW{rgb[0]}};
    p.hs = (h >= HA + HFP && h < HA + HFP + HS) ? SP : ~SP;
    p.vs = (v >= VA + VFP && v < VA + VFP + VS) ? SP : ~SP;
    p.fs = (pos == 0);
    return p;
  endfunction

  function automatic px_t cur_out();
    px_t p;
    p.r   = vif.redOut;
    p.g   = vif.greenOut;
    p.b   = vif.blueOut;
    p.hs  = vif.hSync;
    p.vs  = vif.vSync;
    p.von = vif.videoOn;
    p.fs  = vif.frameStart;
    return p;
  endfunction

  task automatic check(input string name, input px_t act, input px_t exp, input int tag);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s pix=%0d: got r=%h g=%h b=%h hs=%b vs=%b von=%b fs=%b, expected r=%h g=%h b=%h hs=%b vs=%b von=%b fs=%b",
               name, tag, act.r, act.g, act.b, act.hs, act.vs, act.von, act.fs,
               exp.r, exp.g, exp.b, exp.hs, exp.vs, exp.von, exp.fs);
    end
  endtask

  task automatic push(input px_t p, input int tag);
    exp_q.push_back(p);
    tag_q.push_back(tag);
    started = 1'b1;
  endtask

  // One pixel clock of stimulus; expectations are queued for the following edge
  task automatic step(input bit do_release);
    int unsigned k;
    @(negedge clk_in);
    if (do_release) begin
      reset    = 1'b0;
      n        = 0;
      cur_mode = 2'd0;
    end
    if (reset) begin
      push(rst_px(), -1);
    end else begin
      k = n / FRAME;
      if ($urandom_range(499) == 0) vif.mode = 2'($urandom_range(3));
      if ((k >= 18 && k <= 22) || (k >= 26 && k <= 31)) vif.mode = 2'd3;
      push(model_px(n, cur_mode), int'(n));
      if (n % FRAME == FRAME - 1) cur_mode = vif.mode;
      n++;
    end
  endtask

  task automatic assert_reset(input string name);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    check(name, cur_out(), rst_px(), int'(n));
    push(rst_px(), -1);
  endtask

  // Monitor: compare every output pixel against the queued expectation
  initial begin
    px_t e;
    int  t;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check((t < 0) ? "reset_hold" : "pixel", cur_out(), e, t);
      end else if (started) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue_underflow: got an output edge, expected a queued pixel");
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned target;
    vif.mode = 2'd0;
    #1 reset = 1'b1;
    #1 check("reset_initial", cur_out(), rst_px(), 0);
    step(1'b0);
    step(1'b0);
    vif.mode = 2'(1 + $urandom_range(2));
    step(1'b1);
    repeat (FRAME * 38) step(1'b0);

    target = $urandom_range(VT - 1) * HT + $urandom_range(HT - 2, 1);
    while ((n % FRAME) != target) step(1'b0);
    assert_reset("reset_midline");
    step(1'b0);
    step(1'b0);
    vif.mode = 2'($urandom_range(3));
    step(1'b1);
    repeat (FRAME * 2 + 10) step(1'b0);

    @(posedge clk_in);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
